fetch_seq: RTL and testbench
============================

// Module: fetch_seq
// PURPOSE
//  Program-counter sequencer and fetch controller for the 16-bit core. Drives
//  the instruction-memory address, captures the combinational instruction word
//  into an output register and hands it to decode over a valid/ready handshake.
//  Applies branch/jump redirects from execute and stops at the program end.
// PARAMETERS
//  RESET_PC  16'd0  PC loaded on reset and on stop
//  PROG_LEN  16'd9  number of valid imem words; fetch from pc >= PROG_LEN never issued
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   pulse: IDLE -> RUN
//  stop        in   1   pulse: any state -> IDLE, flush, pc <= RESET_PC
//  imem_addr   out  16  instruction-memory address (= pc register)
//  imem_com    in   16  instruction word, combinational from imem_addr
//  dec_valid   out  1   dec_instr/dec_pc hold a valid instruction
//  dec_ready   in   1   decode accepts when dec_valid & dec_ready
//  dec_instr   out  16  registered instruction word
//  dec_pc      out  16  address dec_instr was fetched from
//  redir_valid in   1   execute resolved taken BEQ/J this cycle
//  redir_addr  in   16  absolute redirect target
//  busy        out  1   state == RUN
//  done        out  1   state == DONE
//  fetch_cnt   out  16  instructions fetched since start, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, dec_valid=0, dec_instr=0,
//   dec_pc=0, fetch_cnt=0, busy=0, done=0. Release is synchronous to clk.
//  States: IDLE, RUN, DONE. Priority per cycle: stop > redirect > start > fetch.
//  IDLE: start -> RUN, fetch_cnt<=0. redir_valid ignored. No fetch.
//  RUN, fetch slot = (!dec_valid | dec_ready) & !redir_valid & !stop:
//   - pc < PROG_LEN: dec_instr<=imem_com, dec_pc<=pc, dec_valid<=1, pc<=pc+1,
//     fetch_cnt++ (saturating).
//   - pc >= PROG_LEN: no fetch; dec_valid<=0 if it was consumed; state<=DONE.
//  Not a fetch slot (stall, dec_valid & !dec_ready): dec_* held stable, pc held.
//  Redirect (RUN or DONE): dec_valid<=0 same edge (flush, wrong-path word
//   dropped even if dec_ready=1 that cycle), pc<=redir_addr, state<=RUN.
//   First target instruction valid one edge later (1-cycle bubble).
//  DONE: no fetch; pending dec_valid completes its handshake then drops; start
//   ignored; only redirect or stop leave.
//  stop: dec_valid<=0, pc<=RESET_PC, state<=IDLE; fetch_cnt retained.
//  Latency: start sampled at edge N -> first fetch at edge N+1 -> dec_valid high
//   after N+1. Steady state 1 instr/cycle with dec_ready held 1.
//  pc is 16 bit, +1 wraps 16'hFFFF->0 (unreachable while PROG_LEN bounds it).
//  redir_addr >= PROG_LEN: accepted, next fetch slot moves to DONE.
//  Reset mid-operation: all state returns to reset values immediately.
// TESTING
//  1 Reset, start, dec_ready=1, PROG_LEN=9 -> dec_pc 0..8 on consecutive
//    cycles, dec_instr matches imem, done=1 after pc=9, fetch_cnt=9.
//  2 dec_ready=0 for 3 cycles while dec_pc=3 -> dec_instr/dec_pc/imem_addr
//    stable, fetch_cnt unchanged; ready=1 -> dec_pc 4 next cycle.
//  3 redir_valid with redir_addr=5 while dec_pc=8 (J) and dec_ready=1 ->
//    next cycle dec_valid=0, following cycle dec_pc=5; loop repeats.
//  4 redirect to 7 while in DONE -> state RUN, dec_pc=7 then 8, DONE again.
//  5 stop asserted together with redir_valid -> IDLE, pc=0, dec_valid=0;
//    redirect ignored; start re-runs from 0 with fetch_cnt cleared.
//  6 rst_n low mid-RUN (not on edge) -> dec_valid/busy drop immediately,
//    imem_addr=RESET_PC; start after release restarts cleanly.

Source files
------------

// File: rtl/fetch_seq_if.sv
// Fetch-to-decode handshake: registered instruction word and its address under valid/ready.
interface fetch_seq_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;

  modport master (output dec_valid, output dec_instr, output dec_pc, input dec_ready);
  modport slave  (input dec_valid, input dec_instr, input dec_pc, output dec_ready);
endinterface

// File: rtl/fetch_seq.sv
// PC sequencer/fetch controller: start->first valid one edge later, then 1 instr/cycle; redirect adds a 1-cycle bubble.
// Backpressure: dec_valid & !dec_ready freezes dec_* and pc; nothing is fetched until the held word is accepted.
module fetch_seq #(
  parameter logic [15:0] RESET_PC = 16'd0,
  parameter logic [15:0] PROG_LEN = 16'd9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  output logic [15:0]        imem_addr,
  input  logic [15:0]        imem_com,
  fetch_seq_if.master        dec,
  input  logic               redir_valid,
  input  logic [15:0]        redir_addr,
  output logic               busy,
  output logic               done,
  output logic [15:0]        fetch_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] instr_q, instr_n;
  logic [15:0] dpc_q, dpc_n;
  logic [15:0] cnt_q, cnt_n;
  logic        vld_q, vld_n;
  logic        slot;

  // A slot opens when the output register is empty or being drained this cycle.
  assign slot = !vld_q || dec.dec_ready;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr_q;
    dpc_n   = dpc_q;
    cnt_n   = cnt_q;
    vld_n   = vld_q;
    if (stop) begin
      state_n = IDLE;
      pc_n    = RESET_PC;
      vld_n   = 1'b0;
    end else if (redir_valid && state != IDLE) begin
      // The word sitting in dec_* is wrong-path: drop it even if decode takes it now.
      state_n = RUN;
      pc_n    = redir_addr;
      vld_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = RUN;
            cnt_n   = 16'd0;
          end
        end
        RUN: begin
          if (slot) begin
            if (pc < PROG_LEN) begin
              instr_n = imem_com;
              dpc_n   = pc;
              vld_n   = 1'b1;
              pc_n    = pc + 16'd1;
              cnt_n   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            end else begin
              vld_n   = 1'b0;
              state_n = DONE;
            end
          end
        end
        DONE: begin
          if (vld_q && dec.dec_ready) vld_n = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= 16'd0;
      dpc_q   <= 16'd0;
      cnt_q   <= 16'd0;
      vld_q   <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      instr_q <= instr_n;
      dpc_q   <= dpc_n;
      cnt_q   <= cnt_n;
      vld_q   <= vld_n;
    end
  end

  assign imem_addr     = pc;
  assign dec.dec_valid = vld_q;
  assign dec.dec_instr = instr_q;
  assign dec.dec_pc    = dpc_q;
  assign busy          = (state == RUN);
  assign done          = (state == DONE);
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a scoreboard queue of expected fetch addresses checked by a negedge monitor.
module tb_fetch_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, redir_valid;
  logic [15:0] redir_addr, imem_addr, imem_com, fetch_cnt;
  logic        busy, done;
  logic [15:0] rom [0:15];
  logic [15:0] exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  fetch_seq_if dec_if ();

  fetch_seq #(.RESET_PC(16'd0), .PROG_LEN(16'd9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .imem_addr(imem_addr), .imem_com(imem_com), .dec(dec_if),
    .redir_valid(redir_valid), .redir_addr(redir_addr),
    .busy(busy), .done(done), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  assign imem_com = (imem_addr < 16'd16) ? rom[imem_addr[3:0]] : 16'hDEAD;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(16'(i));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk(name, {15'd0, done}, 16'd1);
  endtask

  // Monitor: a transfer is an accepted word not flushed by redirect/stop in the same cycle.
  always @(negedge clk) begin
    if (rst_n && dec_if.dec_valid && dec_if.dec_ready && !redir_valid && !stop) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_extra: got pc %h with no expected transfer at %0t", dec_if.dec_pc, $time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", dec_if.dec_pc, e);
        chk("sb_instr", dec_if.dec_instr, rom[e[3:0]]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rom[0]  = 16'h1A01; rom[1]  = 16'h2B12; rom[2]  = 16'h3C23; rom[3]  = 16'h4D34;
    rom[4]  = 16'h5E45; rom[5]  = 16'h6F56; rom[6]  = 16'h7067; rom[7]  = 16'h8178;
    rom[8]  = 16'hC005; rom[9]  = 16'hBAD9; rom[10] = 16'hBADA; rom[11] = 16'hBADB;
    rom[12] = 16'hBADC; rom[13] = 16'hBADD; rom[14] = 16'hBADE; rom[15] = 16'hBADF;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; redir_valid = 1'b0; redir_addr = 16'd0;
    dec_if.dec_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", {15'd0, dec_if.dec_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_addr", imem_addr, 16'd0);
    chk("rst_cnt", fetch_cnt, 16'd0);
    chk("rst_dpc", dec_if.dec_pc, 16'd0);
    chk("rst_instr", dec_if.dec_instr, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: full program at one instruction per cycle
    push_range(0, 8);
    do_start();
    chk("t1_bubble", {15'd0, dec_if.dec_valid}, 16'd0);
    for (int i = 0; i <= 8; i++) begin
      tick();
      chk("t1_pc_seq", dec_if.dec_pc, 16'(i));
    end
    tick();
    chk("t1_done", {15'd0, done}, 16'd1);
    chk("t1_valid", {15'd0, dec_if.dec_valid}, 16'd0);
    chk("t1_cnt", fetch_cnt, 16'd9);
    chk("t1_addr", imem_addr, 16'd9);

    // 2: backpressure holds everything
    do_stop();
    chk("t2_cnt_kept", fetch_cnt, 16'd9);
    chk("t2_idle_addr", imem_addr, 16'd0);
    push_range(0, 8);
    do_start();
    for (int i = 0; i < 4; i++) tick();
    chk("t2_at3", dec_if.dec_pc, 16'd3);
    dec_if.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_pc", dec_if.dec_pc, 16'd3);
      chk("t2_hold_instr", dec_if.dec_instr, 16'h4D34);
      chk("t2_hold_addr", imem_addr, 16'd4);
      chk("t2_hold_cnt", fetch_cnt, 16'd4);
    end
    dec_if.dec_ready = 1'b1;
    tick();
    chk("t2_resume", dec_if.dec_pc, 16'd4);
    wait_done("t2_done");

    // 3: jump at pc 8 back to 5, taken twice
    do_stop();
    push_range(0, 7);
    do_start();
    for (int i = 0; i < 9; i++) tick();
    chk("t3_at8", dec_if.dec_pc, 16'd8);
    for (int it = 0; it < 2; it++) begin
      redir_valid = 1'b1; redir_addr = 16'd5;
      tick();
      redir_valid = 1'b0;
      chk("t3_flush", {15'd0, dec_if.dec_valid}, 16'd0);
      chk("t3_addr", imem_addr, 16'd5);
      push_range(5, 7);
      for (int p = 5; p <= 8; p++) begin
        tick();
        chk("t3_loop_pc", dec_if.dec_pc, 16'(p));
      end
    end
    push_range(8, 8);
    wait_done("t3_done");
    chk("t3_cnt", fetch_cnt, 16'd17);

    // 4: redirect out of DONE
    push_range(7, 8);
    redir_valid = 1'b1; redir_addr = 16'd7;
    tick();
    redir_valid = 1'b0;
    chk("t4_busy", {15'd0, busy}, 16'd1);
    chk("t4_valid", {15'd0, dec_if.dec_valid}, 16'd0);
    tick();
    chk("t4_pc7", dec_if.dec_pc, 16'd7);
    tick();
    chk("t4_pc8", dec_if.dec_pc, 16'd8);
    tick();
    chk("t4_done", {15'd0, done}, 16'd1);
    chk("t4_cnt", fetch_cnt, 16'd19);

    // 5: stop wins over redirect; IDLE ignores redirect; start clears count
    do_stop();
    push_range(0, 1);
    do_start();
    for (int i = 0; i < 3; i++) tick();
    stop = 1'b1; redir_valid = 1'b1; redir_addr = 16'd6;
    tick();
    stop = 1'b0; redir_valid = 1'b0;
    chk("t5_busy", {15'd0, busy}, 16'd0);
    chk("t5_valid", {15'd0, dec_if.dec_valid}, 16'd0);
    chk("t5_addr", imem_addr, 16'd0);
    chk("t5_cnt_kept", fetch_cnt, 16'd3);
    redir_valid = 1'b1; redir_addr = 16'd5;
    tick();
    redir_valid = 1'b0;
    tick();
    chk("t5_idle_redir", imem_addr, 16'd0);
    chk("t5_idle_busy", {15'd0, busy}, 16'd0);
    push_range(0, 8);
    do_start();
    chk("t5_cnt_clr", fetch_cnt, 16'd0);
    wait_done("t5_done");
    chk("t5_cnt", fetch_cnt, 16'd9);

    // 6: asynchronous reset mid-run
    do_stop();
    push_range(0, 1);
    do_start();
    for (int i = 0; i < 3; i++) tick();
    dec_if.dec_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", {15'd0, dec_if.dec_valid}, 16'd0);
    chk("t6_busy", {15'd0, busy}, 16'd0);
    chk("t6_addr", imem_addr, 16'd0);
    chk("t6_cnt", fetch_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dec_if.dec_ready = 1'b1;
    tick();
    push_range(0, 8);
    do_start();
    wait_done("t6_done");
    chk("t6_cnt_final", fetch_cnt, 16'd9);

    tick();
    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
